// File: rtl/led_breather.sv
// led_breather: four-mode LED driver (off/on/blink/breathe) stepped by a synchronised slow square wave
module led_breather #(
  parameter int PWM_BITS   = 8,
  parameter int HOLD_STEPS = 16
) (
  input  logic                clk_16mhz,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                step_in,
  output logic                led,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          phase
);
  typedef enum logic [1:0] {RISE, HOLD_HI, FALL, HOLD_LO} state_t;
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] HOLD_LAST = PWM_BITS'(HOLD_STEPS - 1);
  logic                r_sync1, r_sync2, r_prev;
  logic [PWM_BITS-1:0] r_pwm_cnt, r_act_duty, r_hold_cnt, r_duty;
  logic                r_led;
  state_t              r_state;
  logic                w_step_ev;
  logic                w_breathe;
  assign w_step_ev = r_sync2 & ~r_prev;
  assign w_breathe = mode == 2'd3;
  assign led       = r_led;
  assign duty      = r_duty;
  assign phase     = r_state;
  // bring the asynchronous step source into the clock domain and keep its previous level for edge detect
  always_ff @(posedge clk_16mhz) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= step_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end
  // free-running PWM counter, period-aligned duty shadow and registered LED drive
  always_ff @(posedge clk_16mhz) begin
    if (!rst_n) begin
      r_pwm_cnt  <= '0;
      r_act_duty <= '0;
      r_led      <= 1'b0;
    end else begin
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      r_act_duty <= (r_pwm_cnt == DUTY_MAX) ? r_duty : r_act_duty;
      r_led      <= (mode == 2'd0) ? 1'b0 :
                    (mode == 2'd1) ? 1'b1 :
                    (mode == 2'd2) ? r_sync2 : (r_pwm_cnt < r_act_duty);
    end
  end
  // breathe ramp: rise, hold high, fall, hold low; any other mode parks it dark at the start of RISE
  always_ff @(posedge clk_16mhz) begin
    if (!rst_n || !w_breathe) begin
      r_state    <= RISE;
      r_duty     <= '0;
      r_hold_cnt <= '0;
    end else if (w_step_ev) begin
      case (r_state)
        RISE: begin
          r_duty     <= r_duty + 1'b1;
          r_hold_cnt <= '0;
          r_state    <= (r_duty + 1'b1 == DUTY_MAX) ? HOLD_HI : RISE;
        end
        HOLD_HI: begin
          r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? '0 : r_hold_cnt + 1'b1;
          r_state    <= (r_hold_cnt == HOLD_LAST) ? FALL : HOLD_HI;
        end
        FALL: begin
          r_duty     <= r_duty - 1'b1;
          r_hold_cnt <= '0;
          r_state    <= (r_duty - 1'b1 == '0) ? HOLD_LO : FALL;
        end
        default: begin
          r_hold_cnt <= (r_hold_cnt == HOLD_LAST) ? '0 : r_hold_cnt + 1'b1;
          r_state    <= (r_hold_cnt == HOLD_LAST) ? RISE : HOLD_LO;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_led_breather.sv
// tb_led_breather: directed vectors and hand-written sequences for led_breather at PWM_BITS=4, HOLD_STEPS=2
module tb_led_breather;
  logic       clk;
  logic       rst_n;
  logic [1:0] mode;
  logic       step_in;
  logic       led;
  logic [3:0] duty;
  logic [1:0] phase;
  int checks = 0;
  int failures = 0;
  typedef struct packed {
    logic [3:0] duty;
    logic [1:0] phase;
  } vec_t;
  vec_t ramp [34];
  led_breather #(.PWM_BITS(4), .HOLD_STEPS(2)) dut (
    .clk_16mhz(clk),
    .rst_n(rst_n),
    .mode(mode),
    .step_in(step_in),
    .led(led),
    .duty(duty),
    .phase(phase)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse();
    step_in = 1'b1;
    repeat (4) tick();
    step_in = 1'b0;
    repeat (4) tick();
  endtask
  task automatic park();
    mode = 2'd0;
    tick();
    mode = 2'd3;
  endtask
  initial begin
    int highs;
    for (int i = 1; i <= 15; i++) ramp[i-1] = '{duty: 4'(i), phase: (i == 15) ? 2'd1 : 2'd0};
    ramp[15] = '{duty: 4'd15, phase: 2'd1};
    ramp[16] = '{duty: 4'd15, phase: 2'd2};
    for (int j = 1; j <= 15; j++) ramp[16+j] = '{duty: 4'(15 - j), phase: (j == 15) ? 2'd3 : 2'd2};
    ramp[32] = '{duty: 4'd0, phase: 2'd3};
    ramp[33] = '{duty: 4'd0, phase: 2'd0};
    rst_n = 1'b0;
    mode = 2'd3;
    step_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("reset_led", led, 0);
      chk("reset_duty", duty, 0);
      chk("reset_phase", phase, 0);
      mode = 2'(i);
      step_in = ~step_in;
    end
    rst_n = 1'b1;
    mode = 2'd0;
    step_in = 1'b0;
    repeat (4) tick();
    chk("idle_led", led, 0);
    mode = 2'd1;
    tick();
    chk("on_led", led, 1);
    chk("on_duty", duty, 0);
    mode = 2'd0;
    tick();
    chk("off_led", led, 0);
    chk("off_duty", duty, 0);
    mode = 2'd3;
    tick();
    step_in = 1'b1;
    tick();
    tick();
    chk("step_early_duty", duty, 0);
    tick();
    chk("step_duty", duty, 1);
    chk("step_phase", phase, 0);
    tick();
    step_in = 1'b0;
    repeat (18) tick();
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      highs += int'(led);
      tick();
    end
    chk("pwm_duty1_highs", highs, 1);
    park();
    for (int i = 0; i < 34; i++) begin
      pulse();
      chk($sformatf("ramp_duty[%0d]", i), duty, ramp[i].duty);
      chk($sformatf("ramp_phase[%0d]", i), phase, ramp[i].phase);
    end
    park();
    repeat (7) pulse();
    chk("pre_blink_duty", duty, 7);
    step_in = 1'b1;
    tick();
    tick();
    mode = 2'd2;
    tick();
    chk("blink_duty", duty, 0);
    chk("blink_phase", phase, 0);
    chk("blink_led_hi", led, 1);
    step_in = 1'b0;
    tick();
    tick();
    chk("blink_led_lag", led, 1);
    tick();
    chk("blink_led_lo", led, 0);
    mode = 2'd3;
    tick();
    chk("rebreathe_duty0", duty, 0);
    pulse();
    chk("rebreathe_duty1", duty, 1);
    chk("rebreathe_phase", phase, 0);
    park();
    repeat (23) pulse();
    chk("fall_duty", duty, 9);
    chk("fall_phase", phase, 2);
    rst_n = 1'b0;
    tick();
    chk("midreset_duty", duty, 0);
    chk("midreset_phase", phase, 0);
    chk("midreset_led", led, 0);
    rst_n = 1'b1;
    tick();
    pulse();
    chk("postreset_duty", duty, 1);
    chk("postreset_phase", phase, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_breather.md
# led_breather

LED effect engine sitting directly downstream of the prescaler in the FPGA top level. It consumes the prescaler's slow square-wave output as a step source, synchronises it into the 16 MHz domain, and drives the LED pin in one of four modes: off, on, blink, or breathe. Breathe is a PWM triangle ramp with holds at both extremes.

## Interface
- PWM_BITS, 8: width of the PWM counter and duty register; period = 2^PWM_BITS clocks.
- HOLD_STEPS, 16: step events spent in each hold phase; legal range 1 to 2^PWM_BITS-1.

- clk_16mhz  in  1  system clock from the PLL global output.
- rst_n  in  1  reset, synchronous, active-low.
- mode  in  2  effect select: 0 OFF, 1 ON, 2 BLINK, 3 BREATHE.
- step_in  in  1  prescaler clk_out (asynchronous level); each rising edge is one step event.
- led  out  1  registered LED drive.
- duty  out  PWM_BITS  current target duty.
- phase  out  2  breathe state: 0 RISE, 1 HOLD_HI, 2 FALL, 3 HOLD_LO.

## Operation
- Step sync chain: sync1 <= step_in, sync2 <= sync1, prev <= sync2.
  - step_ev = sync2 & ~prev (one clock wide).
- PWM counter pwm_cnt, PWM_BITS wide, always free-running in every mode.
  - Wraps from 2^PWM_BITS-1 to 0.
- Shadow duty act_duty loads from duty on the cycle pwm_cnt == 2^PWM_BITS-1, so a new duty applies from the next period start.
- led next-state by mode:
  - OFF: 0.
  - ON: 1.
  - BLINK: sync2.
  - BREATHE: (pwm_cnt < act_duty).
  - act_duty 0 gives a dark LED. Max duty gives (2^N-1)/2^N on-time, never fully on.
- Breathe FSM advances only on step_ev while mode == 3:
  - RISE: duty += 1. If the new duty == 2^N-1, go to HOLD_HI with hold_cnt = 0.
  - HOLD_HI: hold_cnt += 1. If hold_cnt == HOLD_STEPS-1, go to FALL.
  - FALL: duty -= 1. If the new duty == 0, go to HOLD_LO with hold_cnt = 0.
  - HOLD_LO: same as HOLD_HI, then go to RISE.
- No wrap-around of duty: RISE never increments past max, FALL never decrements below 0.
- Any cycle with mode != 3 forces phase = RISE, duty = 0, hold_cnt = 0.
  - Entering BREATHE always starts from dark.
  - A step_ev in the same cycle is ignored.
- Full breathe period = 2*(2^N-1) + 2*HOLD_STEPS step events.

## Timing
- Reset (rst_n low at a clk_16mhz edge) clears, on that edge:
  - led = 0, duty = 0, phase = 0.
  - pwm_cnt, act_duty, hold_cnt, sync1, sync2 and prev all 0.
- Reset mid-ramp abandons the ramp. After release the block behaves as from power-up.
- step_in high at edge k sets sync1. step_ev is high between edges k+1 and k+2. duty/phase update at edge k+2.
- duty change to act_duty: takes effect at the next pwm_cnt wrap, 1 to 2^N clocks later.
- led is registered: it reflects pwm_cnt/act_duty/mode/sync2 one clock later.
- Step events arriving closer than 2 clocks apart are not required to be distinguished. In practice the prescaler supplies them at Hz rates.
- Mode change takes effect on led at the next edge, with no glitch beyond one registered update.

## Test plan
All scenarios use PWM_BITS=4, HOLD_STEPS=2, with step_in pulsed high 4 clocks, low 4 clocks.
- Reset with all inputs toggling -> led=0, duty=0, phase=0 on the first edge with rst_n low; held while low.
- mode=1 then mode=0 -> led=1 one clock after mode=1, led=0 one clock after mode=0; duty stays 0.
- mode=3, one step_in rising edge sampled at edge k -> duty=1 at edge k+2, not earlier.
  - act_duty=1 after the next pwm_cnt wrap.
  - led high exactly 1 of every 16 clocks.
- mode=3, 15 steps -> duty=15, phase=1.
  - 2 more steps -> phase=2.
  - 15 more steps -> duty=0, phase=3.
  - 2 more steps -> phase=0.
  - Check every intermediate duty value.
- mode=3, ramp to duty=7 -> switch mode=2 coincident with a step_ev -> duty=0, phase=0, led tracks sync2 with 1-clock lag.
  - Back to mode=3 -> restarts from duty=0.
- rst_n low for 1 clock at duty=9 in FALL -> all state 0. Then mode=3 plus 1 step -> duty=1.
